tt_sweep_ctrl: RTL and testbench

- Sequencer that drives a 4-input combinational function block (x0..x3 -> y0) through all 16 input minterms.
- Captures y0 per minterm into a 16-bit truth table; reports match against an expected table plus the on-set size.
- Sits between the test/config host and any exact-synthesis AIG function instance.
- Used for on-chip equivalence checking of synthesized NPN-class netlists.

---
 rtl/tt_sweep_ctrl_if.sv | 23 ++
 rtl/tt_sweep_ctrl.sv | 107 ++++++++++
 tb/tb_tt_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_ctrl_if.sv
// rtl/tt_sweep_ctrl_if.sv - host and function-under-test signal bundle for the truth-table sweeper
interface tt_sweep_ctrl_if;
  logic        start;
  logic [15:0] expected_tt;
  logic [3:0]  x_out;
  logic        y_in;
  logic        busy;
  logic        tt_valid;
  logic        tt_ready;
  logic [15:0] tt_out;
  logic        match;
  logic [4:0]  ones_count;

  modport master (
    output start, expected_tt, y_in, tt_ready,
    input  x_out, busy, tt_valid, tt_out, match, ones_count
  );

  modport slave (
    input  start, expected_tt, y_in, tt_ready,
    output x_out, busy, tt_valid, tt_out, match, ones_count
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - sweeps a 4-input function through all minterms and captures its truth table
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  tt_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  c_q, c_d;
  logic [15:0] tt_q, tt_d;
  logic [15:0] exp_q, exp_d;
  logic        match_q, match_d;
  logic [4:0]  ones_q, ones_d;
  logic [15:0] tt_capt;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      c_q     <= 4'd0;
      tt_q    <= 16'd0;
      exp_q   <= 16'd0;
      match_q <= 1'b0;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      c_q     <= c_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    c_d     = c_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    match_d = match_q;
    ones_d  = ones_q;
    tt_capt = tt_q;
    tt_capt[m_q] = bus.y_in;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          m_d     = 4'd0;
          c_d     = 4'd0;
          tt_d    = 16'd0;
          exp_d   = bus.expected_tt;
          match_d = 1'b0;
          ones_d  = 5'd0;
        end
      end
      SWEEP: begin
        if (c_q != SETTLE) begin
          c_d = c_q + 4'd1;
        end else begin
          c_d  = 4'd0;
          tt_d = tt_capt;
          // Final capture: result flags are registered alongside entry to DONE
          if (m_q == 4'd15) begin
            state_d = DONE;
            match_d = (tt_capt == exp_q);
            ones_d  = popcount16(tt_capt);
          end else begin
            m_d = m_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.tt_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.x_out      = (state_q == SWEEP) ? m_q : 4'd0;
  assign bus.busy       = (state_q == SWEEP);
  assign bus.tt_valid   = (state_q == DONE);
  assign bus.tt_out     = tt_q;
  assign bus.match      = match_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - randomized self-checking bench for tt_sweep_ctrl at SETTLE_CYCLES 1 and 0
module tb_tt_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_sweep_ctrl_if ifa();
  tt_sweep_ctrl_if ifb();

  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  tt_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic        start_r [2];
  logic        ready_r [2];
  logic [15:0] exp_r   [2];
  int          fsel_r  [2];
  logic [15:0] rtab_r  [2];

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  logic [15:0] res_tt;
  logic        res_match;
  logic [4:0]  res_ones;

  function automatic logic fval(input int f, input logic [15:0] tab, input logic [3:0] x);
    case (f)
      0:       return ^x;
      1:       return &x;
      2:       return 1'b1;
      3:       return 1'b0;
      default: return tab[x];
    endcase
  endfunction

  assign ifa.start       = start_r[0];
  assign ifa.tt_ready    = ready_r[0];
  assign ifa.expected_tt = exp_r[0];
  assign ifa.y_in        = fval(fsel_r[0], rtab_r[0], ifa.x_out);
  assign ifb.start       = start_r[1];
  assign ifb.tt_ready    = ready_r[1];
  assign ifb.expected_tt = exp_r[1];
  assign ifb.y_in        = fval(fsel_r[1], rtab_r[1], ifb.x_out);

  logic [3:0]  o_x;
  logic        o_busy, o_valid, o_match;
  logic [15:0] o_tt;
  logic [4:0]  o_ones;

  always_comb begin
    if (sel == 0) begin
      o_x = ifa.x_out; o_busy = ifa.busy; o_valid = ifa.tt_valid;
      o_match = ifa.match; o_tt = ifa.tt_out; o_ones = ifa.ones_count;
    end else begin
      o_x = ifb.x_out; o_busy = ifb.busy; o_valid = ifb.tt_valid;
      o_match = ifb.match; o_tt = ifb.tt_out; o_ones = ifb.ones_count;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (dut %0d) got=%0h expected=%0h", tag, sel, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_x"},     32'(o_x),     32'd0);
    check_eq({tag, "_busy"},  32'(o_busy),  32'd0);
    check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
    check_eq({tag, "_tt"},    32'(o_tt),    32'd0);
    check_eq({tag, "_match"}, 32'(o_match), 32'd0);
    check_eq({tag, "_ones"},  32'(o_ones),  32'd0);
  endtask

  // Full sweep from IDLE; disturb pokes start, tt_ready, expected_tt and the y source mid-sweep
  task automatic run_sweep(input int f, input logic [15:0] exp, input logic [15:0] tab, input bit disturb);
    int s;
    int f_cur;
    logic [15:0] model;
    logic [15:0] exp_lat;
    s = (sel == 0) ? 1 : 0;
    @(negedge clk);
    fsel_r[sel] = f; rtab_r[sel] = tab; exp_r[sel] = exp; start_r[sel] = 1'b1;
    exp_lat = exp; f_cur = f; model = 16'd0;
    @(negedge clk);
    start_r[sel] = 1'b0;
    for (int k = 0; k < 16 * (s + 1); k++) begin
      if (disturb && k == 1) begin
        exp_r[sel] = ~exp;
        fsel_r[sel] = (f == 2) ? 3 : 2;
        f_cur = fsel_r[sel];
        start_r[sel] = 1'b1;
        ready_r[sel] = 1'b1;
      end
      if (disturb && k == 2) begin
        start_r[sel] = 1'b0;
        ready_r[sel] = 1'b0;
      end
      check_eq("sweep_x", 32'(o_x), 32'(k / (s + 1)));
      check_eq("sweep_busy", 32'(o_busy), 32'd1);
      check_eq("sweep_valid", 32'(o_valid), 32'd0);
      if (k % (s + 1) == s) model[k / (s + 1)] = fval(f_cur, tab, 4'(k / (s + 1)));
      @(negedge clk);
    end
    res_tt = model;
    res_match = (model == exp_lat);
    res_ones = 5'($countones(model));
    check_eq("done_valid", 32'(o_valid), 32'd1);
    check_eq("done_busy", 32'(o_busy), 32'd0);
    check_eq("done_x", 32'(o_x), 32'd0);
    check_eq("done_tt", 32'(o_tt), 32'(res_tt));
    check_eq("done_match", 32'(o_match), 32'(res_match));
    check_eq("done_ones", 32'(o_ones), 32'(res_ones));
  endtask

  task automatic hold_done(input int n);
    for (int i = 0; i < n; i++) begin
      start_r[sel] = (i == 3);
      check_eq("hold_valid", 32'(o_valid), 32'd1);
      check_eq("hold_busy", 32'(o_busy), 32'd0);
      check_eq("hold_tt", 32'(o_tt), 32'(res_tt));
      check_eq("hold_match", 32'(o_match), 32'(res_match));
      check_eq("hold_ones", 32'(o_ones), 32'(res_ones));
      @(negedge clk);
    end
    start_r[sel] = 1'b0;
  endtask

  task automatic release_done(input bit with_start);
    ready_r[sel] = 1'b1;
    start_r[sel] = with_start;
    @(negedge clk);
    ready_r[sel] = 1'b0;
    start_r[sel] = 1'b0;
    check_eq("rel_valid", 32'(o_valid), 32'd0);
    check_eq("rel_busy", 32'(o_busy), 32'd0);
    check_eq("rel_tt", 32'(o_tt), 32'(res_tt));
    check_eq("rel_match", 32'(o_match), 32'(res_match));
    check_eq("rel_ones", 32'(o_ones), 32'(res_ones));
    @(negedge clk);
    check_eq("idle_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] tab;
    logic [15:0] exp;
    int f;
    int waited;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; ready_r[i] = 1'b0; exp_r[i] = 16'd0; fsel_r[i] = 3; rtab_r[i] = 16'd0;
    end
    rst = 1'b1;
    #12;
    sel = 0; #1 check_zero("reset");
    sel = 1; #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    sel = 0;
    run_sweep(0, 16'h6996, 16'h0, 1'b0);
    hold_done(10);
    release_done(1'b0);
    run_sweep(1, 16'h8001, 16'h0, 1'b0);
    release_done(1'b1);

    sel = 1;
    run_sweep(2, 16'hFFFF, 16'h0, 1'b0);
    release_done(1'b0);
    run_sweep(3, 16'h0000, 16'h0, 1'b0);
    release_done(1'b0);

    sel = 0;
    run_sweep(0, 16'h1234, 16'h0, 1'b1);
    release_done(1'b0);

    // Reset mid-sweep at minterm 7
    @(negedge clk);
    fsel_r[0] = 2; exp_r[0] = 16'hFFFF; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    waited = 0;
    while (o_x != 4'd7 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("wait_m7", 32'(o_x), 32'd7);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("postrst");
    tab = 16'(($urandom));
    run_sweep(4, tab, tab, 1'b0);
    release_done(1'b0);

    for (int it = 0; it < 12; it++) begin
      sel = it % 2;
      f = $urandom_range(0, 4);
      tab = 16'($urandom);
      exp = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int m = 0; m < 16; m++) exp[m] = fval(f, tab, 4'(m));
      end
      run_sweep(f, exp, tab, 1'($urandom_range(0, 1)));
      hold_done($urandom_range(0, 5));
      release_done(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
